wb_stage: RTL and testbench

- Writeback stage directly upstream of the windowed register file.
- Merges results from the ALU and the load path into the register file's single write port (wr_reg, data, reg_write_en, reg_writeDouble_en, icc, Y).
- Keeps a pending-write scoreboard that decode queries for RAW/WAW hazards.
- Reports idle so decode can safely issue SAVE/RESTORE, which change CWP.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_stage.sv | 163 ++++++++++++++++
 tb/tb_wb_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_pkg : shared types and constants for the writeback stage
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_W            = 5;
    localparam int DATA_W           = 64;
    localparam int NUM_LOGICAL_REGS = 32;
    localparam logic [REG_W-1:0] G0 = '0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              wr_en;
        logic              dbl;
        logic              icc_en;
        logic [3:0]        icc;
        logic              y_en;
    } wb_entry_t;

    // Register pairs always start on the even register.
    function automatic logic [REG_W-1:0] pair_base(input logic [REG_W-1:0] rd);
        return {rd[REG_W-1:1], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo : small synchronous FIFO of writeback entries
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_stage : merges ALU and load results onto the register-file write port
//            and tracks pending destinations for decode hazard checks
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
#(
    parameter int REG_BITS_SIZE = 5,
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_BITS_SIZE-1:0] issue_rd,
    input  logic                     issue_double,
    input  logic [REG_BITS_SIZE-1:0] chk_rs1,
    input  logic [REG_BITS_SIZE-1:0] chk_rs2,
    input  logic [REG_BITS_SIZE-1:0] chk_rd,
    input  logic                     chk_double,
    output logic                     hazard,
    output logic                     wb_idle,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_BITS_SIZE-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     alu_wr_en,
    input  logic                     alu_double,
    input  logic                     alu_icc_en,
    input  logic [3:0]               alu_icc,
    input  logic                     alu_y_en,
    input  logic                     ld_valid,
    input  logic [REG_BITS_SIZE-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_double,
    output logic                     reg_write_en,
    output logic                     reg_writeDouble_en,
    output logic [REG_BITS_SIZE-1:0] wr_reg,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     icc_en,
    output logic [3:0]               icc_in,
    output logic                     Y_en,
    output logic [31:0]              Y_in
);

    wb_entry_t alu_entry, ld_entry, sel_entry, fifo_head;
    logic      fifo_full, fifo_empty;
    logic      alu_fire, bypass, fifo_push, fifo_pop, sel_valid;

    logic                        reg_write_en_q, reg_write_en_d;
    logic                        reg_write_dbl_q, reg_write_dbl_d;
    logic [REG_BITS_SIZE-1:0]    wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        icc_en_q, icc_en_d;
    logic [3:0]                  icc_q, icc_d;
    logic                        y_en_q, y_en_d;
    logic [NUM_LOGICAL_REGS-1:0] sb_q, sb_d;
    logic [REG_BITS_SIZE-1:0]    issue_base;

    assign alu_ready = !reset && !fifo_full;
    assign alu_fire  = alu_valid && alu_ready;
    assign bypass    = alu_fire && !ld_valid && fifo_empty;
    assign fifo_push = alu_fire && !bypass;
    assign fifo_pop  = !ld_valid && !fifo_empty;
    assign sel_valid = ld_valid || !fifo_empty || bypass;

    assign alu_entry = '{rd: alu_rd, data: alu_data, wr_en: alu_wr_en, dbl: alu_double,
                         icc_en: alu_icc_en, icc: alu_icc, y_en: alu_y_en};
    assign ld_entry  = '{rd: ld_rd, data: ld_data, wr_en: 1'b1, dbl: ld_double,
                         icc_en: 1'b0, icc: 4'b0000, y_en: 1'b0};
    assign sel_entry = ld_valid ? ld_entry : (!fifo_empty ? fifo_head : alu_entry);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (alu_entry),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        reg_write_en_d  = 1'b0;
        reg_write_dbl_d = 1'b0;
        wr_reg_d        = wr_reg_q;
        data_d          = data_q;
        icc_en_d        = 1'b0;
        icc_d           = icc_q;
        y_en_d          = 1'b0;
        if (sel_valid) begin
            reg_write_en_d  = sel_entry.wr_en && !sel_entry.dbl;
            reg_write_dbl_d = sel_entry.wr_en && sel_entry.dbl;
            wr_reg_d        = sel_entry.dbl ? pair_base(sel_entry.rd) : sel_entry.rd;
            data_d          = sel_entry.data;
            icc_en_d        = sel_entry.icc_en;
            icc_d           = sel_entry.icc;
            y_en_d          = sel_entry.y_en;
        end
    end

    // Clears apply first so that a same-cycle issue of the same register wins.
    always_comb begin
        sb_d       = sb_q;
        issue_base = issue_double ? pair_base(issue_rd) : issue_rd;
        if (reg_write_en_q || reg_write_dbl_q) begin
            sb_d[wr_reg_q] = 1'b0;
        end
        if (reg_write_dbl_q) begin
            sb_d[{wr_reg_q[REG_BITS_SIZE-1:1], 1'b1}] = 1'b0;
        end
        if (issue_valid) begin
            sb_d[issue_base] = 1'b1;
            if (issue_double) begin
                sb_d[{issue_base[REG_BITS_SIZE-1:1], 1'b1}] = 1'b1;
            end
        end
        sb_d[G0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_en_q  <= 1'b0;
            reg_write_dbl_q <= 1'b0;
            wr_reg_q        <= '0;
            data_q          <= '0;
            icc_en_q        <= 1'b0;
            icc_q           <= '0;
            y_en_q          <= 1'b0;
            sb_q            <= '0;
        end else begin
            reg_write_en_q  <= reg_write_en_d;
            reg_write_dbl_q <= reg_write_dbl_d;
            wr_reg_q        <= wr_reg_d;
            data_q          <= data_d;
            icc_en_q        <= icc_en_d;
            icc_q           <= icc_d;
            y_en_q          <= y_en_d;
            sb_q            <= sb_d;
        end
    end

    assign hazard = sb_q[chk_rs1] || sb_q[chk_rs2] || sb_q[chk_rd] ||
                    (chk_double && sb_q[{chk_rd[REG_BITS_SIZE-1:1], 1'b1}]);
    assign wb_idle = (sb_q == '0) && fifo_empty &&
                     !(reg_write_en_q || reg_write_dbl_q || icc_en_q || y_en_q);

    assign reg_write_en       = reg_write_en_q;
    assign reg_writeDouble_en = reg_write_dbl_q;
    assign wr_reg             = wr_reg_q;
    assign data               = data_q;
    assign icc_en             = icc_en_q;
    assign icc_in             = icc_q;
    assign Y_en               = y_en_q;
    assign Y_in               = data_q[DATA_WIDTH-1 -: 32];

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_stage : directed scoreboard bench for wb_stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid, issue_double, chk_double;
    logic [4:0]  issue_rd, chk_rs1, chk_rs2, chk_rd;
    logic        hazard, wb_idle;
    logic        alu_valid, alu_ready, alu_wr_en, alu_double, alu_icc_en, alu_y_en;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic [3:0]  alu_icc;
    logic        ld_valid, ld_double;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        reg_write_en, reg_writeDouble_en, icc_en, Y_en;
    logic [4:0]  wr_reg;
    logic [63:0] data;
    logic [3:0]  icc_in;
    logic [31:0] Y_in;

    wb_stage #(.REG_BITS_SIZE(5), .DATA_WIDTH(64), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_double(issue_double),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .chk_double(chk_double),
        .hazard(hazard), .wb_idle(wb_idle),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_wr_en(alu_wr_en), .alu_double(alu_double), .alu_icc_en(alu_icc_en),
        .alu_icc(alu_icc), .alu_y_en(alu_y_en),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_double(ld_double),
        .reg_write_en(reg_write_en), .reg_writeDouble_en(reg_writeDouble_en),
        .wr_reg(wr_reg), .data(data), .icc_en(icc_en), .icc_in(icc_in),
        .Y_en(Y_en), .Y_in(Y_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rwe;
        logic        rwd;
        logic [4:0]  wr;
        logic [63:0] data;
        logic        icc_en;
        logic [3:0]  icc;
        logic        y_en;
        logic [31:0] y;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   alu_k;
    logic fired;

    function automatic exp_t mk(input logic rwe, input logic rwd, input logic [4:0] wr,
                                input logic [63:0] d, input logic ie, input logic [3:0] ic,
                                input logic ye);
        return {rwe, rwd, wr, d, ie, ic, ye, d[63:32]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        issue_valid = 0; issue_rd = 0; issue_double = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0; chk_double = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0; alu_wr_en = 0; alu_double = 0;
        alu_icc_en = 0; alu_icc = 0; alu_y_en = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_double = 0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [63:0] d, input logic we,
                             input logic dbl, input logic ie, input logic [3:0] ic,
                             input logic ye);
        alu_valid = 1; alu_rd = rd; alu_data = d; alu_wr_en = we; alu_double = dbl;
        alu_icc_en = ie; alu_icc = ic; alu_y_en = ye;
    endtask

    // Scoreboard monitor: every presented write is compared with the queue head.
    always @(negedge clk) begin
        if (!reset && (reg_write_en || reg_writeDouble_en || icc_en || Y_en)) begin
            mon_act = {reg_write_en, reg_writeDouble_en, wr_reg, data, icc_en, icc_in, Y_en, Y_in};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected act=%h", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL wb_write act=%h exp=%h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        clr_inputs();
        step(); step();
        check("rst_outputs", {reg_write_en, reg_writeDouble_en, wr_reg, icc_en, icc_in, Y_en, Y_in}, 0);
        check("rst_data", data, 0);
        check("rst_ready", alu_ready, 0);
        check("rst_idle", wb_idle, 1);
        reset = 0;
        #1;
        check("ready_after_rst", alu_ready, 1);

        // Single ALU write with pending destination
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0; chk_rs1 = 9;
        #1 check("haz9_set", hazard, 1);
        drive_alu(9, 64'h0000_0000_DEAD_BEEF, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 9, 64'h0000_0000_DEAD_BEEF, 0, 0, 0));
        step();
        alu_valid = 0;
        check("wr9_latency", {reg_write_en, wr_reg}, {1'b1, 5'd9});
        check("haz9_until_write", hazard, 1);
        step();
        check("haz9_clr", hazard, 0);
        check("idle_after_wr9", wb_idle, 1);
        clr_inputs();

        // Load and ALU collide: load first, ALU via FIFO next
        ld_valid = 1; ld_rd = 10; ld_data = 64'hAA;
        drive_alu(11, 64'hBB, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 10, 64'hAA, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 11, 64'hBB, 0, 0, 0));
        step();
        clr_inputs();
        check("collide_ld_first", {reg_write_en, wr_reg}, {1'b1, 5'd10});
        check("collide_ready", alu_ready, 1);
        step();
        check("collide_alu_next", {reg_write_en, wr_reg}, {1'b1, 5'd11});
        step();

        // Loads for 4 cycles while ALU offers every cycle: FIFO fills, order kept
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(1, 0, 5'(c + 1), 64'h100 + 64'(c), 0, 0, 0));
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(1, 0, 5'(20 + k), 64'hA000 + 64'(k), 0, 0, 0));
        alu_k = 0;
        for (int c = 0; c < 10 && alu_k < 3; c++) begin
            ld_valid = (c < 4); ld_rd = 5'(c + 1); ld_data = 64'h100 + 64'(c);
            drive_alu(5'(20 + alu_k), 64'hA000 + 64'(alu_k), 1, 0, 0, 0, 0);
            #1;
            if (c == 2) check("ready_full", alu_ready, 0);
            if (c == 4) check("ready_pop_no_free", alu_ready, 0);
            fired = alu_ready;
            step();
            if (fired) alu_k++;
        end
        clr_inputs();
        check("alu_all_accepted", alu_k, 3);
        step(); step(); step();
        check("idle_after_fill", wb_idle, 1);

        // Double destination and set-wins-over-clear
        issue_valid = 1; issue_rd = 17; issue_double = 1;
        step();
        issue_valid = 0; issue_double = 0; chk_rs2 = 17;
        #1 check("haz17_set", hazard, 1);
        drive_alu(17, 64'h1111_1111_2222_2222, 1, 1, 0, 0, 0);
        exp_q.push_back(mk(0, 1, 16, 64'h1111_1111_2222_2222, 0, 0, 0));
        step();
        alu_valid = 0; issue_valid = 1; issue_rd = 16;
        check("dbl_write", {reg_writeDouble_en, reg_write_en, wr_reg}, {1'b1, 1'b0, 5'd16});
        step();
        issue_valid = 0;
        #1 check("haz17_clr", hazard, 0);
        chk_rs2 = 16;
        #1 check("haz16_set_wins", hazard, 1);
        drive_alu(16, 64'h33, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 16, 64'h33, 0, 0, 0));
        step();
        alu_valid = 0;
        step();
        check("idle_after_dbl", wb_idle, 1);
        clr_inputs();

        // Compare: icc and Y without register write
        drive_alu(3, 64'h0000_00FF_0000_0005, 0, 0, 1, 4'b0100, 1);
        exp_q.push_back(mk(0, 0, 3, 64'h0000_00FF_0000_0005, 1, 4'b0100, 1));
        step();
        clr_inputs();
        check("cmp_flags", {reg_write_en, icc_en, icc_in, Y_en}, {1'b0, 1'b1, 4'b0100, 1'b1});
        check("cmp_y", Y_in, 32'h0000_00FF);
        step();

        // Reset with FIFO full and pending scoreboard bits
        issue_valid = 1; issue_rd = 5;
        step();
        issue_rd = 6; issue_double = 1;
        step();
        issue_valid = 0; issue_double = 0;
        ld_valid = 1; ld_rd = 1; ld_data = 64'h51;
        drive_alu(5, 64'h55, 1, 0, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 1, 64'h51, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 2, 64'h52, 0, 0, 0));
        step();
        ld_rd = 2; ld_data = 64'h52;
        drive_alu(6, 64'h66, 1, 1, 0, 0, 0);
        step();
        clr_inputs();
        chk_rs1 = 5; chk_rs2 = 6; chk_rd = 7;
        #1 check("sb_pre_rst", hazard, 1);
        check("fifo_full_pre_rst", alu_ready, 0);
        reset = 1;
        #1;
        exp_q.delete();
        check("rst_mid_outputs", {reg_write_en, reg_writeDouble_en, wr_reg, icc_en, icc_in, Y_en, Y_in}, 0);
        check("rst_mid_data", data, 0);
        check("rst_mid_ready", alu_ready, 0);
        step();
        reset = 0;
        #1;
        check("idle_after_rst", wb_idle, 1);
        check("sb_cleared", hazard, 0);
        check("ready_after_rst2", alu_ready, 1);
        for (int i = 0; i < 5; i++) step();

        check("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
